// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the alignment rule.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_R = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } lsu_state_e;

    // A half needs an even address, a word a multiple of four; bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        return ((size == SIZE_H) && lo[0]) || ((size == SIZE_W) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus data_memory port of the load/store unit.
// The master side issues requests and serves memory; the slave side is the unit itself.
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned MEM_AW = 6
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_read;
    logic              mem_write;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_read,
               mem_write
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_read,
               mem_write
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends sub-word loads, merges sub-word stores
// into the captured memory word (little-endian lanes, 32-bit words).
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_word,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [1:0]        i_size,
    input  logic [1:0]        i_lane,
    input  logic              i_unsigned,
    output logic [DATA_W-1:0] o_load,
    output logic [DATA_W-1:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sign;

    always_comb begin
        w_byte = i_word[7:0];
        unique case (i_lane)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        w_sign = 1'b0;
        o_load = i_word;
        case (i_size)
            SIZE_B: begin
                w_sign = ~i_unsigned & w_byte[7];
                o_load = {{24{w_sign}}, w_byte};
            end
            SIZE_H: begin
                w_sign = ~i_unsigned & w_half[15];
                o_load = {{16{w_sign}}, w_half};
            end
            default: o_load = i_word;
        endcase
    end

    // Only the addressed lane(s) come from the store data; the rest keep the read word.
    always_comb begin
        o_merged = i_word;
        case (i_size)
            SIZE_B: begin
                unique case (i_lane)
                    2'd0: o_merged[7:0]   = i_wdata[7:0];
                    2'd1: o_merged[15:8]  = i_wdata[7:0];
                    2'd2: o_merged[23:16] = i_wdata[7:0];
                    2'd3: o_merged[31:24] = i_wdata[7:0];
                    default: o_merged = i_word;
                endcase
            end
            SIZE_H: begin
                if (i_lane[1]) begin
                    o_merged[31:16] = i_wdata[15:0];
                end else begin
                    o_merged[15:0] = i_wdata[15:0];
                end
            end
            default: o_merged = i_wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: maps byte/half/word requests onto 32-bit data_memory accesses with
// read-modify-write for sub-word stores. Define MISALIGN_TRAP_EN to trap misaligned requests.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned MEM_AW = 6
) (
    input logic               clk,
    input logic               reset,
    load_store_unit_if.slave  bus
);

    lsu_state_e        r_state;
    logic              r_write;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [1:0]        r_lane;
    logic [DATA_W-1:0] r_wdata;

    logic              r_req_ready;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_resp_err;
    logic [MEM_AW-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_read;
    logic              r_mem_write;

    logic [1:0]        w_size;
    logic [1:0]        w_lane;
    logic              w_trap;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_merged;

    assign w_size = (bus.req_size == SIZE_R) ? SIZE_W : bus.req_size;

`ifdef MISALIGN_TRAP_EN
    assign w_trap = is_misaligned(w_size, bus.req_addr[1:0]);
`else
    assign w_trap = 1'b0;
`endif

    // Force-align: the low address bits below the access size never select a lane.
    always_comb begin
        case (w_size)
            SIZE_B:  w_lane = bus.req_addr[1:0];
            SIZE_H:  w_lane = {bus.req_addr[1], 1'b0};
            default: w_lane = 2'b00;
        endcase
    end

    lsu_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .i_word     (bus.mem_rdata),
        .i_wdata    (r_wdata),
        .i_size     (r_size),
        .i_lane     (r_lane),
        .i_unsigned (r_unsigned),
        .o_load     (w_load),
        .o_merged   (w_merged)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_write      <= 1'b0;
            r_size       <= SIZE_W;
            r_unsigned   <= 1'b0;
            r_lane       <= 2'b00;
            r_wdata      <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_write      <= bus.req_write;
                        r_size       <= w_size;
                        r_unsigned   <= bus.req_unsigned;
                        r_lane       <= w_lane;
                        r_wdata      <= bus.req_wdata;
                        r_mem_addr   <= bus.req_addr[MEM_AW+1:2];
                        r_req_ready  <= 1'b0;
                        r_resp_rdata <= '0;
                        if (w_trap) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_state      <= RESP;
                        end else if (bus.req_write && (w_size == SIZE_W)) begin
                            r_mem_wdata <= bus.req_wdata;
                            r_mem_write <= 1'b1;
                            r_state     <= WR;
                        end else begin
                            r_mem_read <= 1'b1;
                            r_state    <= RD;
                        end
                    end
                end
                RD: begin
                    r_mem_read <= 1'b0;
                    if (r_write) begin
                        r_mem_wdata <= w_merged;
                        r_mem_write <= 1'b1;
                        r_state     <= WR;
                    end else begin
                        r_resp_rdata <= w_load;
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end
                end
                WR: begin
                    r_mem_write  <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_read   = r_mem_read;
    assign bus.mem_write  = r_mem_write;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random traffic against a
// request-level memory model; follows MISALIGN_TRAP_EN when it is defined.
module tb_load_store_unit;
    import lsu_pkg::*;

    typedef struct {
        int          due;
        int          rd;
        int          wr;
        logic [5:0]  idx;
        logic [31:0] wword;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(32), .DATA_W(32), .MEM_AW(6)) bus ();

    load_store_unit #(
        .ADDR_W (32),
        .DATA_W (32),
        .MEM_AW (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [31:0] mem [64];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;
    int          cyc = 0;
    int          wr_count = 0;
    int          rd_count = 0;

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
        else if (pre_en) mem[pre_idx] <= pre_data;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_write) wr_count <= wr_count + 1;
        if (bus.mem_read) rd_count <= rd_count + 1;
    end

    logic [31:0] model [64];
    exp_t        cur;
    int          n_issued = 0;
    int          n_done = 0;
    int          n_abandon = 0;
    int          busy_until = -1;
    logic [31:0] last_rdata;
    logic        last_err;
    int          last_resp_cyc = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the outstanding expected transaction.
    always @(negedge clk) begin
        if (!reset) begin
            bit pend;
            bit exp_rd;
            bit exp_wr;
            bit exp_resp;
            pend     = (n_issued != n_done + n_abandon);
            exp_rd   = pend && (cyc == cur.rd);
            exp_wr   = pend && (cyc == cur.wr);
            exp_resp = pend && (cyc == cur.due);
            chk("req_ready", {31'd0, bus.req_ready}, {31'd0, cyc > busy_until});
            chk("mem_read", {31'd0, bus.mem_read}, {31'd0, exp_rd});
            chk("mem_write", {31'd0, bus.mem_write}, {31'd0, exp_wr});
            chk("resp_valid", {31'd0, bus.resp_valid}, {31'd0, exp_resp});
            if (exp_rd || exp_wr) chk("mem_addr", {26'd0, bus.mem_addr}, {26'd0, cur.idx});
            if (exp_wr) chk("mem_wdata", bus.mem_wdata, cur.wword);
            if (exp_resp) begin
                chk("resp_rdata", bus.resp_rdata, cur.rdata);
                chk("resp_err", {31'd0, bus.resp_err}, {31'd0, cur.err});
                last_rdata    = bus.resp_rdata;
                last_err      = bus.resp_err;
                last_resp_cyc = cyc;
                n_done++;
            end
        end
    end

    function automatic logic [31:0] extend(input logic [31:0] word, input int sz,
                                           input logic [1:0] lo, input bit uns);
        logic [31:0] sh;
        sh = word >> (8 * lo);
        if (sz == 0) begin
            sh = sh & 32'hFF;
            if (!uns && sh[7]) sh = sh | 32'hFFFF_FF00;
        end else if (sz == 1) begin
            sh = sh & 32'hFFFF;
            if (!uns && sh[15]) sh = sh | 32'hFFFF_0000;
        end
        return sh;
    endfunction

    int          pend_idx;
    logic [31:0] pend_old;

    task automatic predict(input int t, input bit w, input logic [1:0] sz_in, input bit uns,
                           input logic [31:0] addr, input logic [31:0] wd);
        exp_t        e;
        int          sz;
        logic [1:0]  lo;
        logic [31:0] mask;
        bit          mis;
        sz      = (sz_in == 2'b11) ? 2 : int'(sz_in);
        lo      = addr[1:0];
        e.idx   = addr[7:2];
        e.rd    = -1;
        e.wr    = -1;
        e.wword = '0;
        e.rdata = '0;
        e.err   = 1'b0;
        mis     = (sz == 1 && lo[0]) || (sz == 2 && lo != 2'b00);
        pend_idx = int'(e.idx);
        pend_old = model[e.idx];
`ifdef MISALIGN_TRAP_EN
        if (mis) begin
            e.due = t + 1;
            e.err = 1'b1;
        end else
`else
        if (mis) lo = (sz == 1) ? {lo[1], 1'b0} : 2'b00;
`endif
        if (!w) begin
            e.rd    = t + 1;
            e.due   = t + 2;
            e.rdata = extend(model[e.idx], sz, lo, uns);
        end else if (sz == 2) begin
            e.wr    = t + 1;
            e.due   = t + 2;
            e.wword = wd;
            model[e.idx] = wd;
        end else begin
            mask    = ((sz == 0) ? 32'hFF : 32'hFFFF) << (8 * lo);
            e.rd    = t + 1;
            e.wr    = t + 2;
            e.due   = t + 3;
            e.wword = (model[e.idx] & ~mask) | ((wd << (8 * lo)) & mask);
            model[e.idx] = e.wword;
        end
        cur        = e;
        busy_until = e.due;
        n_issued++;
    endtask

    task automatic issue(input bit w, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd, input bit hold,
                         output int t);
        int budget;
        @(negedge clk);
        #1;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
        budget = 0;
        while (!bus.req_ready && budget < 20) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (!bus.req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            t = -1;
        end else begin
            t = cyc;
            predict(t, w, sz, uns, addr, wd);
            @(posedge clk);
            #1;
            if (!hold) bus.req_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int budget;
        budget = 0;
        while ((n_issued != n_done + n_abandon) && budget < 20) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (n_issued != n_done + n_abandon) chk("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input bit w, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd, output int lat);
        int t;
        issue(w, sz, uns, addr, wd, 1'b0, t);
        wait_done();
        lat = last_resp_cyc - t;
    endtask

    int lat;
    int t0;
    int t1;
    int t2;
    int wc0;
    int rc0;

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;

        // Clear the memory while the unit is held in reset.
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            pre_en   = 1'b1;
            pre_idx  = 6'(i);
            pre_data = 32'd0;
            model[i] = 32'd0;
        end
        @(negedge clk);
        pre_en = 1'b0;
        chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
        chk("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
        chk("rst_mem_addr", {26'd0, bus.mem_addr}, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        #1;
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Word store then word load.
        wc0 = wr_count;
        run(1'b1, SIZE_W, 1'b0, 32'h10, 32'hDEAD_BEEF, lat);
        chk("t1_store_lat", lat, 2);
        chk("t1_store_pulses", wr_count - wc0, 1);
        chk("t1_mem_word", mem[4], 32'hDEAD_BEEF);
        run(1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, lat);
        chk("t1_load_lat", lat, 2);
        chk("t1_load_data", last_rdata, 32'hDEAD_BEEF);

        // Byte lanes.
        run(1'b1, SIZE_W, 1'b0, 32'h10, 32'h1122_3344, lat);
        run(1'b1, SIZE_B, 1'b0, 32'h13, 32'h0000_00AA, lat);
        chk("t2_store_lat", lat, 3);
        chk("t2_mem_word", mem[4], 32'hAA22_3344);
        run(1'b0, SIZE_B, 1'b0, 32'h13, 32'h0, lat);
        chk("t2_sbyte", last_rdata, 32'hFFFF_FFAA);
        run(1'b0, SIZE_B, 1'b1, 32'h13, 32'h0, lat);
        chk("t2_ubyte", last_rdata, 32'h0000_00AA);
        run(1'b0, SIZE_B, 1'b0, 32'h11, 32'h0, lat);
        chk("t2_sbyte_lane1", last_rdata, 32'h0000_0033);

        // Half lanes.
        run(1'b1, SIZE_W, 1'b0, 32'h14, 32'h0, lat);
        run(1'b1, SIZE_H, 1'b0, 32'h16, 32'h0000_8001, lat);
        chk("t3_mem_word", mem[5], 32'h8001_0000);
        run(1'b0, SIZE_H, 1'b0, 32'h16, 32'h0, lat);
        chk("t3_shalf", last_rdata, 32'hFFFF_8001);
        run(1'b0, SIZE_H, 1'b1, 32'h16, 32'h0, lat);
        chk("t3_uhalf", last_rdata, 32'h0000_8001);

        // Misaligned word load.
        run(1'b1, SIZE_W, 1'b0, 32'h20, 32'hCAFE_F00D, lat);
        rc0 = rd_count;
        run(1'b0, SIZE_W, 1'b0, 32'h21, 32'h0, lat);
`ifdef MISALIGN_TRAP_EN
        chk("t4_err", {31'd0, last_err}, 32'd1);
        chk("t4_lat", lat, 1);
        chk("t4_rdata", last_rdata, 32'd0);
        chk("t4_no_read", rd_count - rc0, 0);
`else
        chk("t4_err", {31'd0, last_err}, 32'd0);
        chk("t4_lat", lat, 2);
        chk("t4_rdata", last_rdata, 32'hCAFE_F00D);
        chk("t4_one_read", rd_count - rc0, 1);
`endif

        // Reset during the read phase of a byte store.
        wc0 = wr_count;
        issue(1'b1, SIZE_B, 1'b0, 32'h10, 32'h0000_0055, 1'b0, t0);
        chk("t5_in_rd", {31'd0, bus.mem_read}, 32'd1);
        reset = 1'b1;
        #1;
        chk("t5_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("t5_mem_read", {31'd0, bus.mem_read}, 32'd0);
        chk("t5_mem_write", {31'd0, bus.mem_write}, 32'd0);
        chk("t5_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("t5_mem_addr", {26'd0, bus.mem_addr}, 32'd0);
        model[pend_idx] = pend_old;
        n_abandon++;
        busy_until = -1;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_no_write", wr_count - wc0, 0);
        chk("t5_mem_kept", mem[4], 32'hAA22_3344);

        // Back-to-back with req_valid held high.
        issue(1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, 1'b1, t0);
        issue(1'b0, SIZE_B, 1'b1, 32'h12, 32'h0, 1'b1, t1);
        issue(1'b1, SIZE_B, 1'b0, 32'h30, 32'h77, 1'b1, t2);
        chk("t6_load_gap", t1 - t0, 3);
        chk("t6_load_gap2", t2 - t1, 3);
        issue(1'b1, SIZE_H, 1'b0, 32'h32, 32'h1234, 1'b0, t0);
        chk("t6_store_gap", t0 - t2, 4);
        wait_done();

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, 1'b0, t0);
            wait_done();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        for (int i = 0; i < 64; i++) chk($sformatf("final_mem[%0d]", i), mem[i], model[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
